mult_accumulator: RTL
=====================

Name: mult_accumulator

Overview:
Downstream consumer of the wallace32 unsigned 32x32 multiplier. It takes the 64-bit product stream and sums a programmed number of products into a guard-banded accumulator, as the MAC/dot-product stage. A valid/ready handshake on the product side lets a registered operand feeder throttle the multiplier. The final sum is presented with a hold-until-acknowledged result handshake.

Parameters:
PW, 64, product width; must match the multiplier output.
GUARD, 8, guard bits above PW; accumulator width is AW = PW+GUARD.
CNT_W, 8, width of the term counter; at most 2^CNT_W-1 terms per run.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
num_terms  input  CNT_W  products to sum; latched on accepted start
prod_in  input  PW  unsigned product from wallace32
prod_valid  input  1  prod_in is valid this cycle
prod_ready  output  1  accumulator accepts prod_in this cycle
acc_out  output  AW  accumulated sum
acc_valid  output  1  acc_out is final; held until acc_ack
acc_ack  input  1  consumer takes the result
busy  output  1  high in ACCUM or DONE
overflow  output  1  sticky; set on carry out of bit AW-1 during the run

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - state = IDLE
  - acc_out = 0, remaining = 0
  - prod_ready = 0, acc_valid = 0, busy = 0, overflow = 0
- Reset asserted mid-run discards the run. There is no partial result.
- State IDLE:
  - prod_ready = 0.
  - prod_valid is ignored.
  - On start: clear acc_out, clear overflow, latch remaining = num_terms.
  - If num_terms != 0, next state is ACCUM. If num_terms == 0, next state is DONE with acc_out = 0.
- State ACCUM:
  - prod_ready = 1 combinationally.
  - A transfer occurs when prod_valid && prod_ready.
  - On a transfer: acc_out <= acc_out + zero-extended prod_in, modulo 2^AW. A carry out sets overflow, which stays set until the next accepted start. remaining decrements.
  - Cycles with prod_valid low change nothing.
  - When the transfer with remaining == 1 occurs, next state is DONE.
  - start is ignored.
- State DONE:
  - acc_valid = 1, prod_ready = 0.
  - acc_out and overflow are stable.
  - On acc_ack, next state is IDLE and acc_valid drops the following cycle.
  - start in DONE is ignored, including when it is coincident with acc_ack; it must be re-presented in IDLE.
- Latency: acc_valid rises on the first clock edge after the final accepted product. There is one register stage and no pipelining of the adder.
- busy = (state != IDLE), registered with the state.
- acc_out remains readable in IDLE until the next start.
- Arithmetic is unsigned only; there is no saturation.

Decomposition:
- Shared package mult_pkg holds:
  - the state enum {IDLE, ACCUM, DONE}
  - PW = 64 and the default GUARD and CNT_W values, shared with the wallace32 test environment
- Single module; no sub-module is warranted. The AW-bit adder is written inline, with carry out taken from an AW+1-bit sum.

Test Plan:
1. Product value 2^62, which is wallace32 on a = b = 2147483648, fed for 2 terms (start, num_terms=2, valid on consecutive cycles) -> acc_out = 2^63 = 0x0000_8000_0000_0000_0000. acc_valid rises on the cycle after the 2nd transfer; overflow = 0.
2. num_terms = 0 -> acc_valid = 1 one cycle after start, acc_out = 0, and prod_ready never asserted.
3. GUARD=1 (AW=65), 3 terms of 2^64-1 -> overflow = 1 and acc_out = (3*(2^64-1)) mod 2^65 = 2^64-3. The next start clears overflow.
4. num_terms = 3 with prod_valid gapped (1,0,0,1,0,1) and values 5, 7, 11 -> acc_out = 23; idle cycles do not decrement the count. prod_valid pulses while in IDLE are not accumulated.
5. Hold acc_ack low for 10 cycles in DONE while pulsing start -> acc_valid and acc_out are steady, with no restart. acc_ack = 1 returns the block to IDLE, with busy = 0 on the next cycle.
6. Assert rst asynchronously (between edges) after 1 of 4 transfers -> all outputs are 0 immediately. After release, a fresh run of 1 term with value 9 yields acc_out = 9.

Source files
------------

// File: rtl/mult_accumulator_pkg.sv
// Shared definitions for the product accumulator and the wallace32 test
// environment.
//   - state_t     : accumulator control states
//   - MP_PW       : product width delivered by wallace32
//   - MP_GUARD    : default number of guard bits above the product width
//   - MP_CNT_W    : default width of the term counter
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MP_PW    = 64;
    localparam int MP_GUARD = 8;
    localparam int MP_CNT_W = 8;

endpackage

// File: rtl/mult_accumulator_if.sv
// Bundle of the run-control, product-stream and result signals of the
// accumulator.
//   master : the environment (operand feeder / result consumer)
//   slave  : the accumulator itself
// Signals:
//   start, num_terms       run request and number of products to sum
//   prod_in, prod_valid    product stream from the multiplier
//   prod_ready             accumulator accepts the product this cycle
//   acc_out, acc_valid     result and its hold-until-ack qualifier
//   acc_ack                consumer takes the result
//   busy, overflow         status
interface mult_accumulator_if
    import mult_pkg::*;
#(
    parameter int PW    = MP_PW,
    parameter int GUARD = MP_GUARD,
    parameter int CNT_W = MP_CNT_W
);
    localparam int AW = PW + GUARD;

    logic             start;
    logic [CNT_W-1:0] num_terms;
    logic [PW-1:0]    prod_in;
    logic             prod_valid;
    logic             prod_ready;
    logic [AW-1:0]    acc_out;
    logic             acc_valid;
    logic             acc_ack;
    logic             busy;
    logic             overflow;

    modport master (
        output start, num_terms, prod_in, prod_valid, acc_ack,
        input  prod_ready, acc_out, acc_valid, busy, overflow
    );

    modport slave (
        input  start, num_terms, prod_in, prod_valid, acc_ack,
        output prod_ready, acc_out, acc_valid, busy, overflow
    );

endinterface

// File: rtl/mult_accumulator.sv
// Sums a programmed number of unsigned products into a guard-banded
// accumulator and presents the result until it is acknowledged.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (discards any run in progress)
//   bus  : mult_accumulator_if.slave (run control, product stream, result)
// The interface instance must be built with the same PW/GUARD/CNT_W values.
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int PW    = MP_PW,
    parameter int GUARD = MP_GUARD,
    parameter int CNT_W = MP_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    mult_accumulator_if.slave   bus
);

    localparam int AW = PW + GUARD;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ACCUM = ACCUM;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]       r_state;
    logic [AW-1:0]    r_acc;
    logic [CNT_W-1:0] r_remaining;
    logic             r_overflow;

    logic             w_xfer;
    logic [AW:0]      w_sum;

    // Products are only accepted while accumulating; all other states
    // ignore prod_valid entirely.
    assign w_xfer = (r_state == S_ACCUM) && bus.prod_valid;

    // One extra bit on the sum captures the carry out of the accumulator.
    assign w_sum = {1'b0, r_acc} + {{(GUARD + 1){1'b0}}, bus.prod_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc       <= '0;
                        r_overflow  <= 1'b0;
                        r_remaining <= bus.num_terms;
                        // A zero-length run completes immediately with 0.
                        r_state     <= (bus.num_terms != '0) ? S_ACCUM : S_DONE;
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        r_acc       <= w_sum[AW-1:0];
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (w_sum[AW])
                            r_overflow <= 1'b1;
                        if (r_remaining == CNT_W'(1))
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here, even when it
                    // coincides with acc_ack.
                    if (bus.acc_ack)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.prod_ready = (r_state == S_ACCUM);
    assign bus.acc_valid  = (r_state == S_DONE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.acc_out    = r_acc;
    assign bus.overflow   = r_overflow;

endmodule
